// File: rtl/cnn_bus_loader.sv
// Bus initiator for the CNN accelerator slave port: streams job words in, waits for the interrupt, reads results back.
// Optional: define CNN_BUS_LOADER_IRQ_CLEAR_EN to write 0 to IRQ_CLR_ADDR before the result reads.
module cnn_bus_loader #(
   parameter logic [31:0] RD_BASE        = 32'hD000_0000,
   parameter int          RD_LATENCY     = 1,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
   parameter logic [31:0] IRQ_CLR_ADDR   = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] cfg_wr_base,
   input  logic [15:0] cfg_wr_words,
   input  logic [7:0]  cfg_rd_words,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   input  logic [31:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [31:0] res_data,
   output logic        res_valid,
   output logic [7:0]  res_index,
   output logic [31:0] awaddr,
   output logic        awvalid,
   output logic [31:0] wdata,
   output logic        wvalid,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic [31:0] rdata,
   input  logic        interrupt_signal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
`ifdef CNN_BUS_LOADER_IRQ_CLEAR_EN
      S_CLR,
`endif
      S_READ,
      S_DONE
   } state_t;

   state_t state, next, after_irq;

   logic [31:0] wr_base_q;
   logic [15:0] wr_words_q;
   logic [7:0]  rd_words_q;
   logic [15:0] wr_cnt;
   logic [7:0]  rd_cnt;
   logic [7:0]  cap_cnt;
   logic [19:0] timer;
   logic        start_acc;
   logic        wr_fire;
   logic        clr_cyc;
   logic        tmo_hit;

   logic [RD_LATENCY-1:0]      vld_p;
   logic [RD_LATENCY-1:0][7:0] idx_p;
   logic [RD_LATENCY:0]        vchain;
   logic [RD_LATENCY:0][7:0]   ichain;

`ifdef CNN_BUS_LOADER_IRQ_CLEAR_EN
   assign clr_cyc = (state == S_CLR);
`else
   assign clr_cyc = 1'b0;
`endif

   always_comb begin
      next      = state;
      src_ready = 1'b0;
      wr_fire   = 1'b0;
      arvalid   = 1'b0;
      tmo_hit   = 1'b0;
      after_irq = (rd_words_q == 8'd0) ? S_DONE : S_READ;
      case (state)
         S_IDLE: begin
            if (start) next = (cfg_wr_words == 16'd0) ? S_WAIT : S_WRITE;
         end
         S_WRITE: begin
            src_ready = 1'b1;
            wr_fire   = src_valid;
            if (src_valid && (wr_cnt == wr_words_q - 16'd1)) next = S_WAIT;
         end
         S_WAIT: begin
            if (interrupt_signal) begin
`ifdef CNN_BUS_LOADER_IRQ_CLEAR_EN
               next = S_CLR;
`else
               next = after_irq;
`endif
            end else if (timer == TIMEOUT_CYCLES - 20'd1) begin
               tmo_hit = 1'b1;
               next    = S_DONE;
            end
         end
`ifdef CNN_BUS_LOADER_IRQ_CLEAR_EN
         S_CLR: next = after_irq;
`endif
         S_READ: begin
            arvalid = (rd_cnt != rd_words_q);
            // Leave only after the final result has been presented.
            if (vld_p[RD_LATENCY-1] && (cap_cnt == rd_words_q - 8'd1)) next = S_DONE;
         end
         S_DONE:  next = S_IDLE;
         default: next = S_IDLE;
      endcase
   end

   assign start_acc = (state == S_IDLE) && start;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign awvalid   = wr_fire | clr_cyc;
   assign wvalid    = awvalid;
   assign awaddr    = clr_cyc ? IRQ_CLR_ADDR :
                      (wr_fire ? wr_base_q + {14'd0, wr_cnt, 2'b00} : 32'd0);
   assign wdata     = wr_fire ? src_data : 32'd0;
   // The accelerator decodes araddr without arvalid, so it must idle at zero.
   assign araddr    = arvalid ? RD_BASE + {22'd0, rd_cnt, 2'b00} : 32'd0;
   assign res_valid = vld_p[RD_LATENCY-1];
   assign res_index = idx_p[RD_LATENCY-1];
   assign vchain    = {vld_p, arvalid};
   assign ichain    = {idx_p, rd_cnt};

   always_ff @(posedge clk) begin
      if (start_acc) begin
         wr_base_q  <= cfg_wr_base;
         wr_words_q <= cfg_wr_words;
         rd_words_q <= cfg_rd_words;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         cap_cnt     <= '0;
         timer       <= '0;
         timeout_err <= 1'b0;
         vld_p       <= '0;
         idx_p       <= '0;
         res_data    <= '0;
      end else begin
         state <= next;
         timer <= (state == S_WAIT) ? timer + 20'd1 : 20'd0;
         if (wr_fire) wr_cnt <= wr_cnt + 16'd1;
         if (arvalid) rd_cnt <= rd_cnt + 8'd1;
         if (vld_p[RD_LATENCY-1]) cap_cnt <= cap_cnt + 8'd1;
         if (tmo_hit) timeout_err <= 1'b1;
         // Read return pipe: stage p[i] holds the read issued i+1 cycles ago.
         vld_p <= vchain[RD_LATENCY-1:0];
         for (int i = 0; i < RD_LATENCY; i++) begin
            if (vchain[i]) idx_p[i] <= ichain[i];
         end
         if (vchain[RD_LATENCY-1]) res_data <= rdata;
         if (start_acc) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            cap_cnt     <= '0;
            timeout_err <= 1'b0;
            idx_p       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cnn_bus_loader.sv
// Directed bench for cnn_bus_loader with RD_LATENCY=3 and TIMEOUT_CYCLES=16; adapts to CNN_BUS_LOADER_IRQ_CLEAR_EN.
module tb_cnn_bus_loader;

   localparam int          LAT   = 3;
   localparam logic [19:0] TMO   = 20'd16;
   localparam logic [31:0] RDB   = 32'hD000_0000;
   localparam logic [31:0] CLRA  = 32'h3000_0000;
   localparam logic [31:0] MAGIC = 32'h0F0F_1234;
`ifdef CNN_BUS_LOADER_IRQ_CLEAR_EN
   localparam int CLR_X = 1;
`else
   localparam int CLR_X = 0;
`endif

   logic        clk, rst, start, busy, done, timeout_err;
   logic [31:0] cfg_wr_base;
   logic [15:0] cfg_wr_words;
   logic [7:0]  cfg_rd_words;
   logic [31:0] src_data, res_data, awaddr, wdata, araddr, rdata;
   logic        src_valid, src_ready, res_valid, awvalid, wvalid, arvalid, interrupt_signal;
   logic [7:0]  res_index;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit mon_en = 0;
   int bad_aw = 0;
   int bad_ar = 0;

   int          aw_c[$];
   logic [31:0] aw_a[$];
   logic [31:0] aw_d[$];
   int          ar_c[$];
   logic [31:0] ar_a[$];
   int          rs_c[$];
   logic [31:0] rs_d[$];
   logic [7:0]  rs_i[$];
   int          dn_c[$];

   cnn_bus_loader #(
      .RD_LATENCY(LAT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_wr_base(cfg_wr_base), .cfg_wr_words(cfg_wr_words), .cfg_rd_words(cfg_rd_words),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .res_data(res_data), .res_valid(res_valid), .res_index(res_index),
      .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wvalid(wvalid),
      .araddr(araddr), .arvalid(arvalid), .rdata(rdata),
      .interrupt_signal(interrupt_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Accelerator read model: rdata for a read appears LAT-1 cycles after its arvalid cycle.
   logic [31:0] apipe [0:LAT-2];
   always @(posedge clk) begin
      apipe[0] <= araddr;
      for (int i = 1; i < LAT - 1; i++) apipe[i] <= apipe[i-1];
   end
   assign rdata = apipe[LAT-2] ^ MAGIC;

   always @(negedge clk) begin
      if (mon_en) begin
         if (awvalid === 1'b1) begin
            aw_c.push_back(cyc); aw_a.push_back(awaddr); aw_d.push_back(wdata);
         end
         if (awvalid !== wvalid) bad_aw++;
         if (src_ready === 1'b1 && awvalid === 1'b1 && src_valid !== 1'b1) bad_aw++;
         if (src_ready === 1'b1 && awvalid === 1'b1 && wdata !== src_data) bad_aw++;
         if (arvalid !== 1'b1 && araddr !== 32'h0) bad_ar++;
         if (arvalid === 1'b1) begin
            ar_c.push_back(cyc); ar_a.push_back(araddr);
         end
         if (res_valid === 1'b1) begin
            rs_c.push_back(cyc); rs_d.push_back(res_data); rs_i.push_back(res_index);
         end
         if (done === 1'b1) dn_c.push_back(cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required finish before it", cyc);
      $fatal(1);
   end

   task automatic clear_logs();
      aw_c.delete(); aw_a.delete(); aw_d.delete();
      ar_c.delete(); ar_a.delete();
      rs_c.delete(); rs_d.delete(); rs_i.delete();
      dn_c.delete();
   endtask

   task automatic start_job(input logic [31:0] base, input logic [15:0] nw, input logic [7:0] nr, output int s);
      @(posedge clk); #1;
      cfg_wr_base = base; cfg_wr_words = nw; cfg_rd_words = nr;
      start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input logic [31:0] d0, input int n, input bit toggle);
      int i = 0;
      int guard = 0;
      bit v = 1'b1;
      while (i < n && guard < 100) begin
         src_valid = v;
         src_data  = d0 + i;
         @(negedge clk);
         if (src_valid && src_ready === 1'b1) i++;
         @(posedge clk); #1;
         if (toggle) v = ~v;
         guard++;
      end
      src_valid = 1'b0;
      src_data  = 32'h0;
      checks++;
      if (i != n) begin
         failures++;
         $display("FAIL feed_accept: got %0d words accepted, required %0d", i, n);
      end
   endtask

   task automatic wait_done(input int budget, output int dc);
      int n = 0;
      dc = -1;
      while (n < budget) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dc = cyc;
            break;
         end
         n++;
      end
      checks++;
      if (dc < 0) begin
         failures++;
         $display("FAIL wait_done: got no done within %0d cycles, required one", budget);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = 32'h0; interrupt_signal = 1'b0;
      cfg_wr_base = 32'h0; cfg_wr_words = 16'h0; cfg_rd_words = 8'h0;
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({busy, done, timeout_err, src_ready, res_valid, awvalid, wvalid, arvalid} !== 8'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b, required 00000000", {busy, done, timeout_err, src_ready, res_valid, awvalid, wvalid, arvalid});
      end
      checks++;
      if ({res_data, res_index, awaddr, wdata, araddr} !== 136'b0) begin
         failures++;
         $display("FAIL reset_data: got res %h idx %h aw %h wd %h ar %h, required all 0", res_data, res_index, awaddr, wdata, araddr);
      end
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      int s, ic, dc, r0;
      clear_logs();
      interrupt_signal = 1'b0;
      start_job(32'h1000_0000, 16'd4, 8'd2, s);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b, required 1", busy); end
      feed(32'hA0, 4, 1'b0);
      repeat (4) @(posedge clk); #1;
      interrupt_signal = 1'b1;
      ic = cyc;
      @(posedge clk); #1;
      interrupt_signal = 1'b0;
      wait_done(60, dc);
      r0 = ic + 1 + CLR_X;
      checks++;
      if (aw_c.size() != 4 + CLR_X) begin
         failures++; $display("FAIL basic_aw_count: got %0d, required %0d", aw_c.size(), 4 + CLR_X);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (aw_a[i] !== 32'h1000_0000 + 4 * i || aw_d[i] !== 32'hA0 + i || aw_c[i] != s + 1 + i) begin
               failures++;
               $display("FAIL basic_aw[%0d]: got addr %h data %h cyc %0d, required %h %h %0d", i, aw_a[i], aw_d[i], aw_c[i], 32'h1000_0000 + 4 * i, 32'hA0 + i, s + 1 + i);
            end
         end
         if (CLR_X == 1) begin
            checks++;
            if (aw_a[4] !== CLRA || aw_d[4] !== 32'h0 || aw_c[4] != ic + 1) begin
               failures++;
               $display("FAIL basic_clr: got addr %h data %h cyc %0d, required %h 0 %0d", aw_a[4], aw_d[4], aw_c[4], CLRA, ic + 1);
            end
         end
      end
      checks++;
      if (ar_c.size() != 2) begin
         failures++; $display("FAIL basic_ar_count: got %0d, required 2", ar_c.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (ar_a[i] !== RDB + 4 * i || ar_c[i] != r0 + i) begin
               failures++;
               $display("FAIL basic_ar[%0d]: got addr %h cyc %0d, required %h %0d", i, ar_a[i], ar_c[i], RDB + 4 * i, r0 + i);
            end
         end
      end
      checks++;
      if (rs_c.size() != 2) begin
         failures++; $display("FAIL basic_res_count: got %0d, required 2", rs_c.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rs_d[i] !== ((RDB + 4 * i) ^ MAGIC) || rs_i[i] !== 8'(i) || rs_c[i] != r0 + i + LAT) begin
               failures++;
               $display("FAIL basic_res[%0d]: got data %h idx %0d cyc %0d, required %h %0d %0d", i, rs_d[i], rs_i[i], rs_c[i], (RDB + 4 * i) ^ MAGIC, i, r0 + i + LAT);
            end
         end
      end
      checks++;
      if (dc != r0 + 1 + LAT + 1) begin
         failures++; $display("FAIL basic_done_cyc: got %0d, required %0d", dc, r0 + 1 + LAT + 1);
      end
      checks++;
      if (busy !== 1'b0 || dn_c.size() != 1) begin
         failures++; $display("FAIL basic_end: got busy %b done pulses %0d, required 0 and 1", busy, dn_c.size());
      end
   endtask

   task automatic test_bubbles();
      int s, dc;
      clear_logs();
      interrupt_signal = 1'b1;
      start_job(32'h2000_0000, 16'd3, 8'd0, s);
      feed(32'hB0, 3, 1'b1);
      wait_done(40, dc);
      interrupt_signal = 1'b0;
      checks++;
      if (aw_c.size() != 3 + CLR_X) begin
         failures++; $display("FAIL bubble_aw_count: got %0d, required %0d", aw_c.size(), 3 + CLR_X);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_a[i] !== 32'h2000_0000 + 4 * i || aw_d[i] !== 32'hB0 + i || aw_c[i] != s + 1 + 2 * i) begin
               failures++;
               $display("FAIL bubble_aw[%0d]: got addr %h data %h cyc %0d, required %h %h %0d", i, aw_a[i], aw_d[i], aw_c[i], 32'h2000_0000 + 4 * i, 32'hB0 + i, s + 1 + 2 * i);
            end
         end
      end
      checks++;
      if (dc != s + 7 + CLR_X || ar_c.size() != 0) begin
         failures++; $display("FAIL bubble_done: got done cyc %0d reads %0d, required %0d and 0", dc, ar_c.size(), s + 7 + CLR_X);
      end
   endtask

   task automatic test_zero();
      int s, dc;
      clear_logs();
      interrupt_signal = 1'b1;
      start_job(32'h0, 16'd0, 8'd0, s);
      wait_done(10, dc);
      interrupt_signal = 1'b0;
      checks++;
      if (dc != s + 2 + CLR_X) begin
         failures++; $display("FAIL zero_done_cyc: got %0d, required %0d", dc, s + 2 + CLR_X);
      end
      checks++;
      if (aw_c.size() != CLR_X || ar_c.size() != 0 || rs_c.size() != 0) begin
         failures++; $display("FAIL zero_traffic: got aw %0d ar %0d res %0d, required %0d 0 0", aw_c.size(), ar_c.size(), rs_c.size(), CLR_X);
      end
   endtask

   task automatic test_timeout();
      int s, dc;
      clear_logs();
      interrupt_signal = 1'b0;
      start_job(32'h4000_0000, 16'd1, 8'd2, s);
      feed(32'hC0, 1, 1'b0);
      wait_done(40, dc);
      checks++;
      if (dc != s + 2 + 16) begin
         failures++; $display("FAIL timeout_done_cyc: got %0d, required %0d", dc, s + 18);
      end
      checks++;
      if (timeout_err !== 1'b1) begin
         failures++; $display("FAIL timeout_err_set: got %b, required 1", timeout_err);
      end
      checks++;
      if (ar_c.size() != 0 || aw_c.size() != 1) begin
         failures++; $display("FAIL timeout_traffic: got ar %0d aw %0d, required 0 and 1", ar_c.size(), aw_c.size());
      end
      interrupt_signal = 1'b1;
      start_job(32'h0, 16'd0, 8'd0, s);
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++; $display("FAIL timeout_err_clear: got %b, required 0", timeout_err);
      end
      wait_done(10, dc);
      interrupt_signal = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      int s;
      bit hit = 1'b0;
      clear_logs();
      interrupt_signal = 1'b1;
      start_job(32'h5000_0000, 16'd1, 8'd4, s);
      feed(32'hD0, 1, 1'b0);
      for (int n = 0; n < 30 && !hit; n++) begin
         @(negedge clk);
         if (arvalid === 1'b1 && araddr === RDB + 32'd4) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         failures++; $display("FAIL midrd_reach: got no read of index 1, required one");
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, timeout_err, src_ready, res_valid, awvalid, wvalid, arvalid} !== 8'b0) begin
         failures++;
         $display("FAIL midrd_ctrl: got %b, required 00000000", {busy, done, timeout_err, src_ready, res_valid, awvalid, wvalid, arvalid});
      end
      checks++;
      if ({res_data, res_index, awaddr, wdata, araddr} !== 136'b0) begin
         failures++;
         $display("FAIL midrd_data: got res %h idx %h aw %h wd %h ar %h, required all 0", res_data, res_index, awaddr, wdata, araddr);
      end
      interrupt_signal = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk); #1;
      checks++;
      if (rs_c.size() != 0 || ar_c.size() != 2 || busy !== 1'b0) begin
         failures++; $display("FAIL midrd_after: got res %0d ar %0d busy %b, required 0 2 0", rs_c.size(), ar_c.size(), busy);
      end
   endtask

   task automatic test_start_ignored();
      int s;
      bit seen = 1'b0;
      clear_logs();
      interrupt_signal = 1'b1;
      start_job(32'h6000_0000, 16'd2, 8'd1, s);
      cfg_wr_words = 16'd7; cfg_rd_words = 8'd5;
      start = 1'b1;
      feed(32'hF0, 2, 1'b0);
      start = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      interrupt_signal = 1'b0;
      repeat (20) @(posedge clk); #1;
      checks++;
      if (dn_c.size() != 1 || aw_c.size() != 2 + CLR_X || ar_c.size() != 1 || rs_c.size() != 1) begin
         failures++;
         $display("FAIL start_ignored: got done %0d aw %0d ar %0d res %0d, required 1 %0d 1 1", dn_c.size(), aw_c.size(), ar_c.size(), rs_c.size(), 2 + CLR_X);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL start_ignored_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_wrap();
      int s, dc;
      logic [31:0] exp_a [0:2];
      exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
      clear_logs();
      interrupt_signal = 1'b1;
      start_job(32'hFFFF_FFF8, 16'd3, 8'd1, s);
      feed(32'hE0, 3, 1'b0);
      wait_done(40, dc);
      interrupt_signal = 1'b0;
      checks++;
      if (aw_c.size() != 3 + CLR_X) begin
         failures++; $display("FAIL wrap_aw_count: got %0d, required %0d", aw_c.size(), 3 + CLR_X);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_a[i] !== exp_a[i] || aw_d[i] !== 32'hE0 + i) begin
               failures++; $display("FAIL wrap_aw[%0d]: got addr %h data %h, required %h %h", i, aw_a[i], aw_d[i], exp_a[i], 32'hE0 + i);
            end
         end
         if (CLR_X == 1) begin
            checks++;
            if (aw_a[3] !== CLRA || aw_d[3] !== 32'h0 || aw_c[3] != s + 5) begin
               failures++; $display("FAIL wrap_clr: got addr %h data %h cyc %0d, required %h 0 %0d", aw_a[3], aw_d[3], aw_c[3], CLRA, s + 5);
            end
         end
      end
      checks++;
      if (ar_c.size() != 1 || rs_c.size() != 1) begin
         failures++; $display("FAIL wrap_rd_count: got ar %0d res %0d, required 1 1", ar_c.size(), rs_c.size());
      end else begin
         checks++;
         if (ar_c[0] != s + 5 + CLR_X || ar_a[0] !== RDB) begin
            failures++; $display("FAIL wrap_ar: got cyc %0d addr %h, required %0d %h", ar_c[0], ar_a[0], s + 5 + CLR_X, RDB);
         end
         checks++;
         if (rs_c[0] != s + 5 + CLR_X + LAT || rs_d[0] !== (RDB ^ MAGIC) || rs_i[0] !== 8'd0) begin
            failures++; $display("FAIL wrap_res: got cyc %0d data %h idx %0d, required %0d %h 0", rs_c[0], rs_d[0], rs_i[0], s + 5 + CLR_X + LAT, RDB ^ MAGIC);
         end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (bad_aw != 0) begin
         failures++; $display("FAIL proto_aw: got %0d bad write cycles, required 0", bad_aw);
      end
      checks++;
      if (bad_ar != 0) begin
         failures++; $display("FAIL proto_ar: got %0d nonzero idle araddr cycles, required 0", bad_ar);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubbles();
      test_zero();
      test_timeout();
      test_reset_mid_read();
      test_start_ignored();
      test_wrap();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
